product_accumulator: RTL and testbench
======================================

# product_accumulator

Downstream consumer of the 16x16 shift-add multiplier. Accepts a stream of unsigned products over a valid/ready handshake and sums them into a wide accumulator. Emits the sum, term count and overflow flag when the input marks the last term of a group. It then clears for the next group. Dot products and multiply-accumulate reductions in the datapath are built from the multiplier plus this block.

## Interface
Parameters:
- PROD_W, 32, width of each incoming product (multiplier result, carry bit excluded)
- ACC_W, 40, accumulator / output sum width; must be ≥ PROD_W
- CNT_W, 8, term counter width

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  product on in_product is valid
- in_ready  out  1  block can accept a product this cycle
- in_product  in  PROD_W  unsigned product, zero-extended to ACC_W
- in_last  in  1  qualifies the accepted product as final term of its group
- out_valid  out  1  result registers hold a completed group
- out_ready  in  1  consumer takes the result this cycle
- out_sum  out  ACC_W  accumulated sum of the group
- out_count  out  CNT_W  number of terms accepted in the group (saturating)
- out_ovf  out  1  sum exceeded 2^ACC_W−1 at some point in the group

## Operation
- Two states:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept = in_valid & in_ready. Both are sampled at the clock edge.
- On accept in ACC:
  - acc ← acc + zext(in_product); cnt ← cnt+1, saturating at 2^CNT_W−1.
  - ovf ← ovf | carry-out of the ACC_W-bit add.
  - If in_last: out_sum/out_count/out_ovf are loaded with the updated values, and the state moves to HOLD.
  - The internal acc/cnt/ovf clear to 0 in the same edge.
- HOLD:
  - out_sum/out_count/out_ovf are held stable until out_valid & out_ready.
  - On that handshake the state returns to ACC.
  - in_ready stays 0 for the whole HOLD state, including the handshake cycle. This gives one bubble between groups.
- No accept in ACC: all state holds.
- Arithmetic is unsigned with no sign extension. The carry is taken from bit ACC_W of an (ACC_W+1)-bit sum.
- A group of one term (in_last on the first accept) is legal: sum = product, count = 1.
- in_last without in_valid is ignored.
- Reset (rst_n=0 at an edge), from either state and mid-group:
  - state=ACC; acc, cnt, ovf cleared.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - The partial group and any pending result are discarded.

## Timing
- Reset values, after the first edge with rst_n=0: in_ready=1 (decoded from state ACC), out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- Throughput: one product per cycle while in ACC.
- Latency: out_valid rises at the edge that accepts the in_last product; results are visible the following cycle.
- out_valid falls the edge after out_valid & out_ready. in_ready returns to 1 in that same cycle.
- in_ready and out_valid are pure decodes of registered state, with no combinational path from in_valid or out_ready.
- Output registers change only on the in_last accept edge or on reset.

## Configuration
- ACC_SATURATE_EN defined:
  - On overflow the accumulator clamps to 2^ACC_W−1 and stays there for the rest of the group.
  - out_ovf=1.
- ACC_SATURATE_EN undefined:
  - The accumulator wraps modulo 2^ACC_W.
  - out_ovf is still set sticky for the group.
- out_count saturation is identical in both builds.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> nothing accepted; after release in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- Group: products 6, 35, 1000 on back-to-back cycles, in_last on 1000, out_ready=1 -> next cycle out_valid=1, out_sum=1041, out_count=3, out_ovf=0; one cycle later out_valid=0 and in_ready=1.
- Backpressure: complete the group {5 (last)} with out_ready=0 for 5 cycles while in_valid=1 with product 9 -> out_sum=5, out_count=1 stable and in_ready=0 throughout; 9 is accepted only after the handshake plus one bubble cycle.
- Overflow: 257 products of 0xFFFF_FFFF, last on the 257th, defaults -> out_count=255, out_ovf=1.
  - With ACC_SATURATE_EN: out_sum=0xFF_FFFF_FFFF.
  - Without it: out_sum=0x00_FFFF_FEFF.
- Single term: product 0 with in_last -> out_sum=0, out_count=1, out_ovf=0.
- Mid-group reset: accept 100 and 200 (no last), pulse rst_n=0 for one cycle, then send 7 with in_last -> out_sum=7, out_count=1, out_ovf=0.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator: sums a stream of unsigned products per group and
// emits sum/count/overflow when the group's last term is accepted.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    product handshake (in_product, in_last)
//   out_valid/out_ready  result handshake (out_sum, out_count, out_ovf)
//
// Build option: define ACC_SATURATE_EN to clamp the accumulator at
// 2^ACC_W-1 on overflow instead of wrapping modulo 2^ACC_W.

module product_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic {
        S_ACC  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           state_q,  state_d;
    logic [ACC_W-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             ovf_q,    ovf_d;
    logic [ACC_W-1:0] sum_q,    sum_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             oovf_q,   oovf_d;

    logic             accept;
    logic [ACC_W:0]   add_full;
    logic             carry;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;

    // Handshake flags decode registered state only.
    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_HOLD);
    assign out_sum   = sum_q;
    assign out_count = count_q;
    assign out_ovf   = oovf_q;

    assign accept = in_valid & in_ready;

    // One extra bit on the add so the carry-out is the overflow indicator.
    assign add_full = {1'b0, acc_q} + (ACC_W+1)'(in_product);
    assign carry    = add_full[ACC_W];
    assign ovf_next = ovf_q | carry;
    assign cnt_next = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef ACC_SATURATE_EN
    // Once clamped, the sum stays pinned at max for the rest of the group.
    assign acc_next = ovf_next ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
    assign acc_next = add_full[ACC_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum_d   = sum_q;
        count_d = count_q;
        oovf_d  = oovf_q;
        unique case (state_q)
            S_ACC: begin
                if (accept) begin
                    if (in_last) begin
                        sum_d   = acc_next;
                        count_d = cnt_next;
                        oovf_d  = ovf_next;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = S_HOLD;
                    end else begin
                        acc_d = acc_next;
                        cnt_d = cnt_next;
                        ovf_d = ovf_next;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_ACC;
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            oovf_q  <= oovf_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: scoreboard bench for product_accumulator.
// Expected group results are queued on the last accept and popped on handshake.

module tb_product_accumulator;

    localparam int PROD_W = 32;
    localparam int ACC_W  = 40;
    localparam int CNT_W  = 8;

    localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PROD_W-1:0] in_product = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    typedef struct {
        longint unsigned sum;
        longint unsigned count;
        longint unsigned ovf;
    } res_t;

    res_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: exact total in 64 bits, plain term count.
    longint unsigned m_total = 0;
    longint unsigned m_terms = 0;

    product_accumulator #(
        .PROD_W(PROD_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_product(in_product),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint unsigned got,
                       input longint unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic res_t model_result();
        res_t r;
        r.ovf = (m_total > ACC_MAX) ? 1 : 0;
`ifdef ACC_SATURATE_EN
        r.sum = (m_total > ACC_MAX) ? ACC_MAX : m_total;
`else
        r.sum = m_total % (ACC_MAX + 1);
`endif
        r.count = (m_terms > 255) ? 255 : m_terms;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one product and wait (bounded) for the edge that accepts it.
    task automatic send(input logic [PROD_W-1:0] p, input logic last);
        bit done;
        done       = 0;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        for (int i = 0; i < 50 && !done; i++) begin
            done = in_ready;
            tick();
        end
        if (!done) chk("accept_timeout", 0, 1);
        else begin
            m_total += p;
            m_terms += 1;
            if (last) begin
                q.push_back(model_result());
                m_total = 0;
                m_terms = 0;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Result monitor: compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                res_t e;
                e = q.pop_front();
                chk("out_sum", out_sum, e.sum);
                chk("out_count", out_count, e.count);
                chk("out_ovf", out_ovf, e.ovf);
            end
        end
    end

    initial begin
        // Reset with in_valid asserted: nothing may be taken.
        tick();
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_product = 32'd123;
        in_last    = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_ovf", out_ovf, 0);
        tick();
        chk("rst_idle_valid", out_valid, 0);

        // Basic group.
        out_ready = 1'b1;
        send(32'd6, 1'b0);
        send(32'd35, 1'b0);
        send(32'd1000, 1'b1);
        chk("grp_valid", out_valid, 1);
        chk("grp_ready_low", in_ready, 0);
        chk("grp_sum", out_sum, 1041);
        chk("grp_count", out_count, 3);
        tick();
        chk("grp_valid_fall", out_valid, 0);
        chk("grp_ready_back", in_ready, 1);

        // Backpressure: result held, input stalled.
        out_ready = 1'b0;
        send(32'd5, 1'b1);
        in_valid   = 1'b1;
        in_product = 32'd9;
        in_last    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_ready", in_ready, 0);
            chk("bp_sum", out_sum, 5);
            chk("bp_count", out_count, 1);
            tick();
        end
        out_ready = 1'b1;
        chk("bp_hs_ready", in_ready, 0);
        tick();
        chk("bp_bubble_valid", out_valid, 0);
        chk("bp_bubble_ready", in_ready, 1);
        send(32'd9, 1'b1);
        chk("bp9_sum", out_sum, 9);
        tick();

        // Overflow over 257 max-valued products.
        for (int i = 0; i < 257; i++) begin
            send(32'hFFFF_FFFF, (i == 256));
        end
        chk("ovf_count", out_count, 255);
        chk("ovf_flag", out_ovf, 1);
`ifdef ACC_SATURATE_EN
        chk("ovf_sum", out_sum, 40'hFF_FFFF_FFFF);
`else
        chk("ovf_sum", out_sum, 40'h00_FFFF_FEFF);
`endif
        tick();

        // Single zero term.
        send(32'd0, 1'b1);
        chk("one_sum", out_sum, 0);
        chk("one_count", out_count, 1);
        chk("one_ovf", out_ovf, 0);
        tick();

        // Mid-group reset discards the partial sum.
        send(32'd100, 1'b0);
        send(32'd200, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        m_total = 0;
        m_terms = 0;
        chk("mid_rst_ready", in_ready, 1);
        send(32'd7, 1'b1);
        chk("mid_sum", out_sum, 7);
        chk("mid_count", out_count, 1);
        chk("mid_ovf", out_ovf, 0);

        // A few random groups.
        for (int g = 0; g < 4; g++) begin
            tick();
            for (int t = 0; t < 3 + g; t++) begin
                send($urandom, (t == 2 + g));
            end
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
